// File: rtl/sync_fifo_flags_if.sv
// Bus bundle for sync_fifo_flags: write/read requests, data and status flags.
// master drives requests and data in; slave (the FIFO) drives data out and status.
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, din, rd_en,
    input  dout, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, din, rd_en,
    output dout, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with optional first-word-fall-through read, programmable
// almost-full/almost-empty thresholds, occupancy count, sticky error flags and flush.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_flags_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full, empty, wr_acc, rd_acc;

  // Handshake: a write is taken on any edge where wr_en && !full, a read on any
  // edge where rd_en && !empty; both judged on pre-edge state, flush blocks both.
  always_comb begin
    full        = (count_q == DEPTH_C);
    empty       = (count_q == '0);
    wr_acc      = bus.wr_en && !full;
    rd_acc      = bus.rd_en && !empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
        default: count_d = count_q;
      endcase
      if (bus.wr_en && full)  overflow_d  = 1'b1;
      if (bus.rd_en && empty) underflow_d = 1'b1;
    end
  end

  // Storage is never cleared; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && wr_acc) mem_q[wr_ptr_q] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always presented; rd_en merely advances past it.
      assign bus.dout     = mem_q[rd_ptr_q];
      assign bus.rd_valid = !empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q, dout_d;
      logic                  rd_valid_q, rd_valid_d;

      always_comb begin
        dout_d     = dout_q;
        rd_valid_d = 1'b0;
        if (bus.flush) begin
          dout_d = '0;
        end else if (rd_acc) begin
          dout_d     = mem_q[rd_ptr_q];
          rd_valid_d = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q     <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          dout_q     <= dout_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign bus.dout     = dout_q;
      assign bus.rd_valid = rd_valid_q;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: one registered-read instance and one FWFT instance.
module tb_sync_fifo_flags;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if0 ();
  sync_fifo_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if1 ();

  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if0.flush = 1'b0; if0.wr_en = 1'b0; if0.rd_en = 1'b0; if0.din = 8'h00;
    if1.flush = 1'b0; if1.wr_en = 1'b0; if1.rd_en = 1'b0; if1.din = 8'h00;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write0(input logic [7:0] d);
    if0.wr_en = 1'b1; if0.din = d;
    tick();
    if0.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (if0.count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", if0.count); end
    n_vec++; if ({if0.empty, if0.full, if0.almost_empty, if0.almost_full} !== 4'b1010) begin
      n_err++; $display("FAIL reset_flags got e/f/ae/af=%b want 1010",
                        {if0.empty, if0.full, if0.almost_empty, if0.almost_full}); end
    n_vec++; if ({if0.overflow, if0.underflow, if0.rd_valid} !== 3'b000) begin
      n_err++; $display("FAIL reset_err got ovf/unf/vld=%b want 000", {if0.overflow, if0.underflow, if0.rd_valid}); end
    n_vec++; if (if0.dout !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h want 00", if0.dout); end
    n_vec++; if ({if1.empty, if1.rd_valid} !== 2'b10) begin
      n_err++; $display("FAIL reset_fwft got empty/vld=%b want 10", {if1.empty, if1.rd_valid}); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      write0(8'(i));
      n_vec++; if (if0.count !== 5'(i + 1)) begin
        n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, if0.count, i + 1); end
      n_vec++; if ({if0.almost_empty, if0.almost_full, if0.full} !==
                   {(i + 1) <= 2, (i + 1) >= 14, (i + 1) == 16}) begin
        n_err++; $display("FAIL fill_flags[%0d] got ae/af/f=%b want %b", i,
                          {if0.almost_empty, if0.almost_full, if0.full},
                          {(i + 1) <= 2, (i + 1) >= 14, (i + 1) == 16}); end
    end
    write0(8'hFF);
    n_vec++; if (if0.overflow !== 1'b1) begin n_err++; $display("FAIL fill_overflow got %b want 1", if0.overflow); end
    n_vec++; if (if0.count !== 5'd16) begin n_err++; $display("FAIL fill_ovf_count got %0d want 16", if0.count); end
  endtask

  task automatic test_read_latency();
    do_reset();
    for (int i = 0; i < 4; i++) write0(8'hA0 + 8'(i));
    if0.rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (if0.dout !== 8'hA0 + 8'(i)) begin
        n_err++; $display("FAIL rd_dout[%0d] got %h want %h", i, if0.dout, 8'hA0 + 8'(i)); end
      n_vec++; if (if0.rd_valid !== 1'b1) begin
        n_err++; $display("FAIL rd_valid[%0d] got %b want 1", i, if0.rd_valid); end
    end
    tick();
    if0.rd_en = 1'b0;
    n_vec++; if ({if0.underflow, if0.rd_valid} !== 2'b10) begin
      n_err++; $display("FAIL rd_underflow got unf/vld=%b want 10", {if0.underflow, if0.rd_valid}); end
    n_vec++; if (if0.dout !== 8'hA3) begin n_err++; $display("FAIL rd_hold got %h want a3", if0.dout); end
  endtask

  task automatic test_fwft();
    do_reset();
    if1.wr_en = 1'b1; if1.din = 8'h5A;
    tick();
    if1.wr_en = 1'b0;
    n_vec++; if (if1.dout !== 8'h5A) begin n_err++; $display("FAIL fwft_dout got %h want 5a", if1.dout); end
    n_vec++; if ({if1.rd_valid, if1.empty} !== 2'b10) begin
      n_err++; $display("FAIL fwft_valid got vld/empty=%b want 10", {if1.rd_valid, if1.empty}); end
    if1.rd_en = 1'b1;
    tick();
    if1.rd_en = 1'b0;
    n_vec++; if ({if1.rd_valid, if1.empty, if1.underflow} !== 3'b010) begin
      n_err++; $display("FAIL fwft_pop got vld/empty/unf=%b want 010", {if1.rd_valid, if1.empty, if1.underflow}); end
    if1.wr_en = 1'b1; if1.din = 8'h11; tick();
    if1.din = 8'h22; tick();
    if1.wr_en = 1'b0;
    n_vec++; if (if1.dout !== 8'h11) begin n_err++; $display("FAIL fwft_head got %h want 11", if1.dout); end
    if1.rd_en = 1'b1; tick(); if1.rd_en = 1'b0;
    n_vec++; if (if1.dout !== 8'h22) begin n_err++; $display("FAIL fwft_next got %h want 22", if1.dout); end
  endtask

  task automatic test_steady();
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      write0(8'(i));
      exp_q.push_back(8'(i));
    end
    if0.wr_en = 1'b1; if0.rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] exp_d;
      if0.din = 8'(8 + i);
      exp_q.push_back(8'(8 + i));
      tick();
      exp_d = exp_q.pop_front();
      n_vec++; if (if0.count !== 5'd8) begin
        n_err++; $display("FAIL steady_count[%0d] got %0d want 8", i, if0.count); end
      n_vec++; if (if0.dout !== exp_d || if0.rd_valid !== 1'b1) begin
        n_err++; $display("FAIL steady_data[%0d] got %h/%b want %h/1", i, if0.dout, if0.rd_valid, exp_d); end
    end
    idle();
  endtask

  task automatic test_full_empty_both();
    do_reset();
    for (int i = 0; i < 16; i++) write0(8'h30 + 8'(i));
    if0.wr_en = 1'b1; if0.rd_en = 1'b1; if0.din = 8'hEE;
    tick();
    idle();
    n_vec++; if ({if0.count, if0.overflow} !== {5'd15, 1'b1}) begin
      n_err++; $display("FAIL full_both got count=%0d ovf=%b want 15/1", if0.count, if0.overflow); end
    n_vec++; if (if0.dout !== 8'h30) begin n_err++; $display("FAIL full_both_dout got %h want 30", if0.dout); end
    do_reset();
    if0.wr_en = 1'b1; if0.rd_en = 1'b1; if0.din = 8'h77;
    tick();
    idle();
    n_vec++; if ({if0.count, if0.underflow, if0.overflow, if0.rd_valid} !== {5'd1, 3'b100}) begin
      n_err++; $display("FAIL empty_both got count=%0d unf/ovf/vld=%b want 1/100",
                        if0.count, {if0.underflow, if0.overflow, if0.rd_valid}); end
  endtask

  task automatic test_flush();
    do_reset();
    if0.rd_en = 1'b1; tick(); if0.rd_en = 1'b0;
    for (int i = 0; i < 9; i++) write0(8'h60 + 8'(i));
    n_vec++; if ({if0.count, if0.underflow} !== {5'd9, 1'b1}) begin
      n_err++; $display("FAIL preflush got count=%0d unf=%b want 9/1", if0.count, if0.underflow); end
    if0.flush = 1'b1; if0.wr_en = 1'b1; if0.din = 8'hEE;
    tick();
    idle();
    n_vec++; if ({if0.count, if0.empty, if0.almost_empty, if0.underflow, if0.overflow} !== {5'd0, 4'b1100}) begin
      n_err++; $display("FAIL flush got count=%0d e/ae/unf/ovf=%b want 0/1100",
                        if0.count, {if0.empty, if0.almost_empty, if0.underflow, if0.overflow}); end
    write0(8'h42);
    if0.rd_en = 1'b1; tick(); if0.rd_en = 1'b0;
    n_vec++; if ({if0.dout, if0.rd_valid, if0.count} !== {8'h42, 1'b1, 5'd0}) begin
      n_err++; $display("FAIL postflush got dout=%h vld=%b count=%0d want 42/1/0", if0.dout, if0.rd_valid, if0.count); end
    for (int i = 0; i < 3; i++) write0(8'h90 + 8'(i));
    rst = 1'b1; if0.flush = 1'b1; if0.wr_en = 1'b1; if0.din = 8'hDD;
    tick();
    rst = 1'b0;
    idle();
    n_vec++; if ({if0.count, if0.empty, if0.full, if0.rd_valid, if0.dout} !== {5'd0, 3'b100, 8'h00}) begin
      n_err++; $display("FAIL rst_flush got count=%0d e/f/vld=%b dout=%h want 0/100/00",
                        if0.count, {if0.empty, if0.full, if0.rd_valid}, if0.dout); end
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_read_latency();
    test_fwft();
    test_steady();
    test_full_empty_both();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
